// File: rtl/demux_pkg.sv
// Shared types and defaults for the demux_deser serial-to-parallel lane demultiplexer.
package demux_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int DEMUX_N_DEFAULT = 8;

endpackage

// File: rtl/demux_lane_dec.sv
// One-hot lane decoder: turns a lane index into per-lane write strobes, all zero unless accepting.
module demux_lane_dec
    import demux_pkg::*;
#(
    parameter int N     = DEMUX_N_DEFAULT,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [SEL_W-1:0] i_lane,
    input  logic             i_accept,
    output logic [N-1:0]     o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_accept) begin
            o_onehot[i_lane] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_deser.sv
// Sequential 1-to-N demultiplexer that collects one bit per lane and presents the lanes as a frame.
// Optional feature macro: DEMUX_DESER_PARITY_EN adds a registered out_parity port (^y of the frame).
module demux_deser
    import demux_pkg::*;
#(
    parameter int N     = DEMUX_N_DEFAULT,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             din,
    input  logic             auto_mode,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             o_dbg_state,
    output logic [N-1:0]     o_dbg_mask,
    output logic [SEL_W-1:0] o_dbg_ptr
`ifdef DEMUX_DESER_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    // Handshakes: a bit transfers on an edge where in_valid & in_ready; a frame is
    // consumed on an edge where out_valid & out_ready. Both ready/valid depend only on state.

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_y;
    logic [N-1:0]     r_mask;
    logic [SEL_W-1:0] r_ptr;

    logic             w_accept;
    logic             w_release;
    logic             w_complete;
    logic [SEL_W-1:0] w_lane;
    logic [N-1:0]     w_we;
    logic [N-1:0]     w_mask_next;
    logic [N-1:0]     w_y_next;

    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready;
    assign w_lane    = auto_mode ? r_ptr : sel;

    demux_lane_dec #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_lane_dec (
        .i_lane   (w_lane),
        .i_accept (w_accept),
        .o_onehot (w_we)
    );

    assign w_mask_next = r_mask | w_we;
    assign w_y_next    = (r_y & ~w_we) | (w_we & {N{din}});
    // Completion needs a fresh accept: rewriting a lane on a full mask cannot happen in COLLECT.
    assign w_complete  = w_accept & (&w_mask_next);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_complete) w_state_next = HOLD;
            HOLD:    if (out_ready)  w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_y     <= '0;
            r_mask  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_y    <= w_y_next;
                r_mask <= w_mask_next;
                if (auto_mode) begin
                    r_ptr <= r_ptr + SEL_W'(1);
                end
            end
            // y is deliberately left alone on release; it is only replaced lane by lane.
            if (w_release) begin
                r_mask <= '0;
                r_ptr  <= '0;
            end
        end
    end

`ifdef DEMUX_DESER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_complete) begin
            r_parity <= ^w_y_next;
        end
    end

    assign out_parity = r_parity;
`endif

    assign y           = r_y;
    assign o_dbg_state = r_state;
    assign o_dbg_mask  = r_mask;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_demux_deser.sv
// Directed bench for demux_deser: lane-array model, per-cycle compare, frame scoreboard.
module tb_demux_deser;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             din = 1'b0;
    logic             auto_mode = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic [N-1:0]     y;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             dbg_state;
    logic [N-1:0]     dbg_mask;
    logic [SEL_W-1:0] dbg_ptr;
`ifdef DEMUX_DESER_PARITY_EN
    logic             out_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux_deser #(.N(N), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din         (din),
        .auto_mode   (auto_mode),
        .sel         (sel),
        .y           (y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .o_dbg_state (dbg_state),
        .o_dbg_mask  (dbg_mask),
        .o_dbg_ptr   (dbg_ptr)
`ifdef DEMUX_DESER_PARITY_EN
        ,
        .out_parity  (out_parity)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: lanes as separate bits, written-lane flags, pointer as an int
    bit   m_lane[N];
    bit   m_written[N];
    int   m_ptr = 0;
    bit   m_hold = 0;
    bit   m_par = 0;
    logic [N-1:0] exp_q[$];

    function automatic logic [N-1:0] lanes_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_lane[i];
        return v;
    endfunction

    function automatic logic [N-1:0] written_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_written[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_lane[i]    = 1'b0;
                m_written[i] = 1'b0;
            end
            m_ptr  = 0;
            m_hold = 0;
            m_par  = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                int lane;
                int filled;
                lane = auto_mode ? m_ptr : int'(sel);
                m_lane[lane]    = din;
                m_written[lane] = 1'b1;
                if (auto_mode) m_ptr = (m_ptr + 1) % N;
                filled = 0;
                for (int i = 0; i < N; i++) filled += int'(m_written[i]);
                if (filled == N) begin
                    m_hold = 1;
                    m_par  = 0;
                    for (int i = 0; i < N; i++) m_par = m_par ^ m_lane[i];
                    exp_q.push_back(lanes_vec());
                end
            end
        end else if (out_ready) begin
            m_hold = 0;
            m_ptr  = 0;
            for (int i = 0; i < N; i++) m_written[i] = 1'b0;
        end
    end

    // per-cycle compare plus frame scoreboard on each consumed frame
    always @(negedge clk) begin
        check("y",         32'(y),         32'(lanes_vec()));
        check("out_valid", 32'(out_valid), 32'(m_hold));
        check("in_ready",  32'(in_ready),  32'(!m_hold));
        check("state",     32'(dbg_state), 32'(m_hold));
        check("mask",      32'(dbg_mask),  32'(written_vec()));
        check("ptr",       32'(dbg_ptr),   32'(m_ptr));
`ifdef DEMUX_DESER_PARITY_EN
        if (m_hold) check("parity", 32'(out_parity), 32'(m_par));
`endif
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 32'(out_valid), 32'(0));
            end else begin
                check("frame", 32'(y), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic cyc(input logic v, input logic d, input logic am,
                       input logic [SEL_W-1:0] s, input logic ordy);
        in_valid  = v;
        din       = d;
        auto_mode = am;
        sel       = s;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic release_frame();
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        out_ready = 1'b0;
    endtask

    logic [7:0] pat;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y",        32'(y),         32'h0);
        check("rst_in_ready", 32'(in_ready),  32'h1);
        check("rst_valid",    32'(out_valid), 32'h0);
        rst = 1'b0;

        // auto mode, 8'h33 LSB first
        pat = 8'h33;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t1_valid_early", 32'(out_valid), 32'h0);
            cyc(1'b1, pat[i], 1'b1, '0, 1'b0);
        end
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_y",     32'(y),         32'h33);
        check("t1_ready", 32'(in_ready),  32'h0);
`ifdef DEMUX_DESER_PARITY_EN
        check("t1_parity", 32'(out_parity), 32'h0);
`endif

        // held frame ignores input for 5 cycles
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i), 1'b1, '0, 1'b0);
        check("hold_y",     32'(y),         32'h33);
        check("hold_valid", 32'(out_valid), 32'h1);
        // bit offered with out_ready is not taken
        cyc(1'b1, 1'b0, 1'b1, '0, 1'b1);
        out_ready = 1'b0;
        check("rel_valid", 32'(out_valid), 32'h0);
        check("rel_ptr",   32'(dbg_ptr),   32'h0);
        check("rel_mask",  32'(dbg_mask),  32'h0);
        check("rel_y",     32'(y),         32'h33);

        // explicit mode, sel 7..0
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t2_valid_early", 32'(out_valid), 32'h0);
            cyc(1'b1, 1'((i + 1) % 2), 1'b0, SEL_W'(7 - i), 1'b0);
        end
        check("t2_valid", 32'(out_valid), 32'h1);
        check("t2_y",     32'(y),         32'hAA);
        release_frame();

        // explicit, lane 3 rewritten three times, then the rest with 0
        cyc(1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
        check("t3_mask_rewrite", 32'(dbg_mask), 32'h08);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                if (i == 7) check("t3_valid_early", 32'(out_valid), 32'h0);
                cyc(1'b1, 1'b0, 1'b0, SEL_W'(i), 1'b0);
            end
        end
        check("t3_valid", 32'(out_valid), 32'h1);
        check("t3_y",     32'(y),         32'h08);
        release_frame();

        // reset after 4 accepted bits aborts the frame
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, '0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, '0, 1'b0);
        rst = 1'b0;
        check("t4_y",     32'(y),         32'h0);
        check("t4_mask",  32'(dbg_mask),  32'h0);
        check("t4_ptr",   32'(dbg_ptr),   32'h0);
        check("t4_valid", 32'(out_valid), 32'h0);
        pat = 8'h07;
        for (int i = 0; i < 8; i++) cyc(1'b1, pat[i], 1'b1, '0, 1'b0);
        check("t4_frame_y", 32'(y), 32'h07);
`ifdef DEMUX_DESER_PARITY_EN
        check("t4_parity", 32'(out_parity), 32'h1);
`endif
        release_frame();

        // mode switches mid-frame with idle gaps
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, '0, 1'b0);
        idle();
        cyc(1'b1, 1'b1, 1'b0, 3'd6, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        check("t5_ptr_kept", 32'(dbg_ptr), 32'h3);
        pat = 8'b0001_0101;
        for (int i = 0; i < 5; i++) cyc(1'b1, pat[i], 1'b1, 3'd2, 1'b0);
        check("t5_valid", 32'(out_valid), 32'h1);
        check("t5_y",     32'(y),         32'hAE);
        release_frame();
        idle();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
